// File: rtl/ppu_video_pkg.sv
// Shared video timing defaults, scanout state encoding and output record.
package ppu_video_pkg;

  // Default SVGA 800x600 timing (clocks for horizontal, lines for vertical).
  localparam int SVGA_H_FRONT = 40;
  localparam int SVGA_H_SYNC  = 128;
  localparam int SVGA_H_BACK  = 88;
  localparam int SVGA_V_FRONT = 1;
  localparam int SVGA_V_SYNC  = 4;
  localparam int SVGA_V_BACK  = 23;

  // Pixel width of the framebuffer bank this block is paired with.
  localparam int VID_COLOR_W = 16;

  // Scanout run state: idle holds the raster at (0,0), run sweeps frames.
  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } scan_state_t;

  // One registered video output beat.
  typedef struct packed {
    logic [VID_COLOR_W-1:0] pixel;
    logic                   de;
    logic                   hsync;
    logic                   vsync;
  } video_out_t;

  // Total span of a line or frame: active region plus porches and sync.
  function automatic int span_total(input int active, input int front,
                                    input int sync, input int back);
    return active + front + sync + back;
  endfunction

endpackage

// File: rtl/ppu_scanout_if.sv
// Bundle of the framebuffer read port and the video output stream.
//
// Read contract: there is no handshake. The scanout presents raddress/rselect
// every clock (changing only on active pixels) and the bank returns the word
// on rdata exactly one clock later, unconditionally. The video side is a pure
// stream: vid_* and frame_start are valid every clock with no back-pressure.
interface ppu_scanout_if #(
  parameter int COLOR_WIDTH   = 16,
  parameter int BUFFER_ADDR_W = 32,
  parameter int SEL_W         = 4
);
  logic [BUFFER_ADDR_W-1:0] raddress;
  logic [SEL_W-1:0]         rselect;
  logic [COLOR_WIDTH-1:0]   rdata;
  logic [COLOR_WIDTH-1:0]   vid_pixel;
  logic                     vid_de;
  logic                     vid_hsync;
  logic                     vid_vsync;
  logic                     frame_start;

  // Scanout side: issues reads, consumes read data, drives video.
  modport master (
    output raddress, rselect,
    input  rdata,
    output vid_pixel, vid_de, vid_hsync, vid_vsync, frame_start
  );

  // Bank/display side: serves reads, observes video.
  modport slave (
    input  raddress, rselect,
    output rdata,
    input  vid_pixel, vid_de, vid_hsync, vid_vsync, frame_start
  );
endinterface

// File: rtl/ppu_video_timing.sv
// Raster counters, run/idle control and fetch-stage video flags.
module ppu_video_timing
  import ppu_video_pkg::*;
#(
  parameter int X       = 800,
  parameter int Y       = 600,
  parameter int H_FRONT = SVGA_H_FRONT,
  parameter int H_SYNC  = SVGA_H_SYNC,
  parameter int H_BACK  = SVGA_H_BACK,
  parameter int V_FRONT = SVGA_V_FRONT,
  parameter int V_SYNC  = SVGA_V_SYNC,
  parameter int V_BACK  = SVGA_V_BACK
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        enable_i,
  output logic        active_o,
  output logic        hs_o,
  output logic        vs_o,
  output logic        first_o,
  output logic        frame_wrap_o,
  output scan_state_t state_o
);

  localparam int HT  = span_total(X, H_FRONT, H_SYNC, H_BACK);
  localparam int VT  = span_total(Y, V_FRONT, V_SYNC, V_BACK);
  localparam int H_W = $clog2(HT);
  localparam int V_W = $clog2(VT);

  localparam logic [H_W-1:0] H_LAST   = H_W'(HT - 1);
  localparam logic [H_W-1:0] X_END    = H_W'(X);
  localparam logic [H_W-1:0] HS_START = H_W'(X + H_FRONT);
  localparam logic [H_W-1:0] HS_END   = H_W'(X + H_FRONT + H_SYNC);
  localparam logic [V_W-1:0] V_LAST   = V_W'(VT - 1);
  localparam logic [V_W-1:0] Y_END    = V_W'(Y);
  localparam logic [V_W-1:0] VS_START = V_W'(Y + V_FRONT);
  localparam logic [V_W-1:0] VS_END   = V_W'(Y + V_FRONT + V_SYNC);

  scan_state_t    state_q, state_d;
  logic [H_W-1:0] h_cnt_q, h_cnt_d;
  logic [V_W-1:0] v_cnt_q, v_cnt_d;
  logic           running;
  logic           at_wrap;

  assign running = (state_q == ST_RUN);
  // Last clock of the frame: the next edge returns the raster to (0,0).
  assign at_wrap = running && (h_cnt_q == H_LAST) && (v_cnt_q == V_LAST);

  // Run/idle decision: enable only matters while parked at (0,0) or at the
  // wrap back to (0,0); mid-frame changes are ignored until the frame ends.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: if (enable_i)              state_d = ST_RUN;
      ST_RUN:  if (at_wrap && !enable_i)  state_d = ST_IDLE;
      default:                            state_d = ST_IDLE;
    endcase
  end

  // Raster counters advance while running and are parked at (0,0) otherwise.
  always_comb begin
    h_cnt_d = h_cnt_q;
    v_cnt_d = v_cnt_q;
    if (!running) begin
      h_cnt_d = '0;
      v_cnt_d = '0;
    end else if (h_cnt_q == H_LAST) begin
      h_cnt_d = '0;
      v_cnt_d = (v_cnt_q == V_LAST) ? '0 : v_cnt_q + V_W'(1);
    end else begin
      h_cnt_d = h_cnt_q + H_W'(1);
    end
  end

  // State and counter registers.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= ST_IDLE;
      h_cnt_q <= '0;
      v_cnt_q <= '0;
    end else begin
      state_q <= state_d;
      h_cnt_q <= h_cnt_d;
      v_cnt_q <= v_cnt_d;
    end
  end

  assign active_o     = running && (h_cnt_q < X_END) && (v_cnt_q < Y_END);
  assign hs_o         = running && (h_cnt_q >= HS_START) && (h_cnt_q < HS_END);
  assign vs_o         = running && (v_cnt_q >= VS_START) && (v_cnt_q < VS_END);
  assign first_o      = running && (h_cnt_q == '0) && (v_cnt_q == '0);
  assign frame_wrap_o = at_wrap;
  assign state_o      = state_q;

endmodule

// File: rtl/ppu_scanout.sv
// Framebuffer scanout: raster timing, interleaved read addressing, latency
// alignment and registered video output.
module ppu_scanout
  import ppu_video_pkg::*;
#(
  parameter int COLOR_WIDTH   = VID_COLOR_W,
  parameter int SCREEN_X_SIZE = 800,
  parameter int SCREEN_Y_SIZE = 600,
  parameter int CORES_COUNT   = 10,
  parameter int BUFFER_ADDR_W = 32,
  parameter int H_FRONT       = SVGA_H_FRONT,
  parameter int H_SYNC        = SVGA_H_SYNC,
  parameter int H_BACK        = SVGA_H_BACK,
  parameter int V_FRONT       = SVGA_V_FRONT,
  parameter int V_SYNC        = SVGA_V_SYNC,
  parameter int V_BACK        = SVGA_V_BACK
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              enable_i,
  ppu_scanout_if.master     bus,
  output scan_state_t       dbg_state_o
);

  localparam int SEL_W = (CORES_COUNT > 1) ? $clog2(CORES_COUNT) : 1;
  localparam logic [SEL_W-1:0] SEL_LAST = SEL_W'(CORES_COUNT - 1);

  // Fetch-stage flags travel one register behind the address before the
  // output register, so they meet the bank data that belongs to them.
  typedef struct packed {
    logic de;
    logic hs;
    logic vs;
    logic first;
  } stage_flags_t;

  logic fetch_active, fetch_hs, fetch_vs, fetch_first, frame_wrap;

  ppu_video_timing #(
    .X       (SCREEN_X_SIZE),
    .Y       (SCREEN_Y_SIZE),
    .H_FRONT (H_FRONT),
    .H_SYNC  (H_SYNC),
    .H_BACK  (H_BACK),
    .V_FRONT (V_FRONT),
    .V_SYNC  (V_SYNC),
    .V_BACK  (V_BACK)
  ) u_timing (
    .clk          (clk),
    .reset_n      (reset_n),
    .enable_i     (enable_i),
    .active_o     (fetch_active),
    .hs_o         (fetch_hs),
    .vs_o         (fetch_vs),
    .first_o      (fetch_first),
    .frame_wrap_o (frame_wrap),
    .state_o      (dbg_state_o)
  );

  logic [BUFFER_ADDR_W-1:0] raddr_q, raddr_d;
  logic [SEL_W-1:0]         rsel_q, rsel_d;
  stage_flags_t             stg_q, stg_d;
  video_out_t               out_q, out_d;
  logic                     fs_q, fs_d;
  logic [COLOR_WIDTH-1:0]   pix_sel;

  // Interleaved address walk: the registers always hold the address of the
  // pixel currently in the fetch stage. Each active pixel steps the bank
  // select; a select wrap steps the per-bank address. Blanking holds them,
  // and the frame wrap rewinds both to pixel 0.
  always_comb begin
    raddr_d = raddr_q;
    rsel_d  = rsel_q;
    if (frame_wrap) begin
      raddr_d = '0;
      rsel_d  = '0;
    end else if (fetch_active) begin
      if (rsel_q == SEL_LAST) begin
        rsel_d  = '0;
        raddr_d = raddr_q + BUFFER_ADDR_W'(1);
      end else begin
        rsel_d  = rsel_q + SEL_W'(1);
      end
    end
  end

  // Address registers.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      raddr_q <= '0;
      rsel_q  <= '0;
    end else begin
      raddr_q <= raddr_d;
      rsel_q  <= rsel_d;
    end
  end

  // Fetch-stage flags captured while the bank works on the read.
  always_comb begin
    stg_d       = '0;
    stg_d.de    = fetch_active;
    stg_d.hs    = fetch_hs;
    stg_d.vs    = fetch_vs;
    stg_d.first = fetch_first;
  end

  // Output beat: bank data is passed only under data-enable, black otherwise.
  always_comb begin
    pix_sel     = stg_q.de ? bus.rdata : '0;
    out_d       = '0;
    out_d.pixel = pix_sel;
    out_d.de    = stg_q.de;
    out_d.hsync = stg_q.hs;
    out_d.vsync = stg_q.vs;
    fs_d        = stg_q.first;
  end

  // Delay stage and output register; every video pin comes from a flop.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      stg_q <= '0;
      out_q <= '0;
      fs_q  <= 1'b0;
    end else begin
      stg_q <= stg_d;
      out_q <= out_d;
      fs_q  <= fs_d;
    end
  end

  assign bus.raddress    = raddr_q;
  assign bus.rselect     = rsel_q;
  assign bus.vid_pixel   = out_q.pixel;
  assign bus.vid_de      = out_q.de;
  assign bus.vid_hsync   = out_q.hsync;
  assign bus.vid_vsync   = out_q.vsync;
  assign bus.frame_start = fs_q;

endmodule

// File: tb/tb_ppu_scanout.sv
// Bench for ppu_scanout: a small raster instance checked cycle by cycle
// against an independent timing/pixel model, plus a default SVGA instance
// checked over its first two lines.
module tb_ppu_scanout;
  import ppu_video_pkg::*;

  // Small configuration
  localparam int X     = 8;
  localparam int Y     = 4;
  localparam int CORES = 4;
  localparam int HT    = X + 2 + 2 + 2;   // 14
  localparam int VT    = Y + 1 + 1 + 1;   // 7
  localparam int FRAME = HT * VT;         // 98
  localparam int W     = 16;

  // Default configuration
  localparam int D_X  = 800;
  localparam int D_HT = 800 + 40 + 128 + 88; // 1056

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic reset_n;
  logic enable;
  logic enable_d;
  always #5 clk = ~clk;

  ppu_scanout_if #(.COLOR_WIDTH(W), .BUFFER_ADDR_W(32), .SEL_W(2)) sif ();
  ppu_scanout_if #(.COLOR_WIDTH(W), .BUFFER_ADDR_W(32), .SEL_W(4)) dif ();
  scan_state_t s_state;
  scan_state_t d_state;

  ppu_scanout #(
    .COLOR_WIDTH(W), .SCREEN_X_SIZE(X), .SCREEN_Y_SIZE(Y), .CORES_COUNT(CORES),
    .BUFFER_ADDR_W(32), .H_FRONT(2), .H_SYNC(2), .H_BACK(2),
    .V_FRONT(1), .V_SYNC(1), .V_BACK(1)
  ) dut (
    .clk(clk), .reset_n(reset_n), .enable_i(enable), .bus(sif), .dbg_state_o(s_state)
  );

  ppu_scanout dut_def (
    .clk(clk), .reset_n(reset_n), .enable_i(enable_d), .bus(dif), .dbg_state_o(d_state)
  );

  // Bank models: return {rselect, raddress} one clock after the request.
  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) sif.rdata <= '0;
    else          sif.rdata <= {sif.rselect, sif.raddress[13:0]};
  end
  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) dif.rdata <= '0;
    else          dif.rdata <= {dif.rselect, dif.raddress[11:0]};
  end

  // ---------------- scoreboard ----------------
  int vectors = 0;
  int miscompares = 0;
  logic [W-1:0] exp_q[$];

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // ---------------- driver tasks ----------------
  // Waits for frame_start on the chosen instance, sampling 1 unit after each
  // rising edge; returns limit+1 if it never arrives.
  task automatic wait_fs(input bit dflt, input int limit, output int cycles);
    logic fs;
    cycles = 0;
    do begin
      @(posedge clk); #1;
      cycles++;
      fs = dflt ? dif.frame_start : sif.frame_start;
    end while (fs !== 1'b1 && cycles <= limit);
  endtask

  task automatic cycles_n(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // ---------------- output monitor (small instance) ----------------
  bit mon_en = 1'b0;
  bit tracking = 1'b0;
  int pos = 0;
  int mh, mv;
  logic [W-1:0] got_exp;

  always @(negedge clk) begin
    if (!reset_n) begin
      tracking = 1'b0;
      pos = 0;
      exp_q.delete();
    end else if (mon_en) begin
      if (sif.frame_start === 1'b1) begin
        if (tracking) check("fs_period", 64'(pos), 64'(FRAME));
        check("fs_leftover", 64'(exp_q.size()), 64'd0);
        for (int n = 0; n < X * Y; n++)
          exp_q.push_back({2'(n % CORES), 14'(n / CORES)});
        tracking = 1'b1;
        pos = 0;
      end else if (tracking && pos == FRAME) begin
        tracking = 1'b0;
      end
      if (tracking) begin
        mh = pos % HT;
        mv = pos / HT;
        check("de",    64'(sif.vid_de),    64'((mh < X && mv < Y) ? 1 : 0));
        check("hsync", 64'(sif.vid_hsync), 64'((mh >= X + 2 && mh < X + 4) ? 1 : 0));
        check("vsync", 64'(sif.vid_vsync), 64'((mv == Y + 1) ? 1 : 0));
        if (sif.vid_de === 1'b1) begin
          got_exp = (exp_q.size() > 0) ? exp_q.pop_front() : 'x;
          check("pixel", 64'(sif.vid_pixel), 64'(got_exp));
        end else begin
          check("pixel_blank", 64'(sif.vid_pixel), 64'd0);
        end
        pos++;
      end else begin
        check("idle_out", 64'({sif.vid_pixel, sif.vid_de, sif.vid_hsync,
                               sif.vid_vsync, sif.frame_start}), 64'd0);
      end
    end
  end

  // ---------------- directed sequence ----------------
  int c;
  int de_cnt, hs_cnt, vs_cnt;

  initial begin
    reset_n  = 1'b0;
    enable   = 1'b1;
    enable_d = 1'b0;

    // Reset state with enable high
    repeat (3) @(negedge clk);
    check("rst_de",    64'(sif.vid_de),      64'd0);
    check("rst_pixel", 64'(sif.vid_pixel),   64'd0);
    check("rst_sync",  64'({sif.vid_hsync, sif.vid_vsync}), 64'd0);
    check("rst_fs",    64'(sif.frame_start), 64'd0);
    check("rst_addr",  64'(sif.raddress),    64'd0);
    check("rst_sel",   64'(sif.rselect),     64'd0);
    check("rst_state", 64'(s_state),         64'(ST_IDLE));

    // Release: first request (0,0), then (1,0); first pixel two clocks later
    reset_n = 1'b1;
    mon_en  = 1'b1;
    @(posedge clk); #1;
    check("rel_addr",  64'({sif.rselect, sif.raddress}), 64'd0);
    check("rel_state", 64'(s_state), 64'(ST_RUN));
    @(posedge clk); #1;
    check("rel_sel1",  64'(sif.rselect), 64'd1);
    check("rel_de0",   64'(sif.vid_de),  64'd0);
    @(posedge clk); #1;
    check("rel_de1",   64'(sif.vid_de),      64'd1);
    check("rel_fs",    64'(sif.frame_start), 64'd1);
    check("rel_sel2",  64'(sif.rselect),     64'd2);

    // Second frame follows after exactly one frame period
    wait_fs(1'b0, 120, c);
    check("frame_period", 64'(c), 64'(FRAME));

    // Drop enable around pixel (3,2): frame completes, no restart
    repeat (31) @(posedge clk);
    @(negedge clk);
    enable = 1'b0;
    wait_fs(1'b0, 150, c);
    check("no_restart", 64'(c), 64'd151);
    check("stop_state", 64'(s_state), 64'(ST_IDLE));
    check("stop_addr",  64'({sif.rselect, sif.raddress}), 64'd0);

    // Re-enable: new frame from (0,0)
    @(negedge clk);
    enable = 1'b1;
    wait_fs(1'b0, 10, c);
    check("restart_lat", 64'(c), 64'd3);

    // Asynchronous reset in line 2
    cycles_n(33);
    #1;
    reset_n = 1'b0;
    #1;
    check("arst_out", 64'({sif.vid_pixel, sif.vid_de, sif.vid_hsync,
                           sif.vid_vsync, sif.frame_start}), 64'd0);
    check("arst_addr", 64'({sif.rselect, sif.raddress}), 64'd0);
    check("arst_state", 64'(s_state), 64'(ST_IDLE));
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    wait_fs(1'b0, 10, c);
    check("arst_restart", 64'(c), 64'd3);
    wait_fs(1'b0, 120, c);
    check("arst_period", 64'(c), 64'(FRAME));
    @(negedge clk);
    enable = 1'b0;
    cycles_n(110);
    check("end_state", 64'(s_state), 64'(ST_IDLE));
    check("end_queue", 64'(exp_q.size()), 64'd0);
    mon_en = 1'b0;

    // Default SVGA instance: first two lines
    @(negedge clk);
    enable_d = 1'b1;
    wait_fs(1'b1, 10, c);
    check("def_fs_lat", 64'(c), 64'd3);
    de_cnt = 0; hs_cnt = 0; vs_cnt = 0;
    for (int i = 0; i < 2 * D_HT; i++) begin
      if (dif.vid_de === 1'b1)    de_cnt++;
      if (dif.vid_hsync === 1'b1) hs_cnt++;
      if (dif.vid_vsync === 1'b1) vs_cnt++;
      if (i == 0)        check("def_pix0",    64'(dif.vid_pixel), 64'({4'd0, 12'd0}));
      if (i == D_X - 1)  check("def_pix799",  64'(dif.vid_pixel), 64'({4'd9, 12'd79}));
      if (i == D_X)      check("def_de_fall", 64'(dif.vid_de),    64'd0);
      if (i == D_HT)     check("def_pix800",  64'(dif.vid_pixel), 64'({4'd0, 12'd80}));
      @(posedge clk); #1;
    end
    check("def_de_cnt", 64'(de_cnt), 64'(2 * D_X));
    check("def_hs_cnt", 64'(hs_cnt), 64'(2 * 128));
    check("def_vs_cnt", 64'(vs_cnt), 64'd0);
    @(negedge clk);
    enable_d = 1'b0;

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/ppu_scanout.md
Name: ppu_scanout

Overview:
Display-side reader of the per-core interleaved framebuffer memory bank. It generates SVGA-style raster timing and issues one framebuffer read per active pixel as a raddress/rselect pair. It absorbs the bank's read latency and drives an aligned video stream of pixel, data-enable, hsync and vsync to the display PHY. It sits between the framebuffer bank read port and the video output pins.

Parameters:
COLOR_WIDTH, 16, pixel width; must match the framebuffer bank.
SCREEN_X_SIZE, 800, active pixels per line.
SCREEN_Y_SIZE, 600, active lines per frame.
CORES_COUNT, 10, number of interleaved banks. SCREEN_X_SIZE*SCREEN_Y_SIZE must be divisible by CORES_COUNT.
BUFFER_ADDR_W, 32, width of the per-bank read address.
H_FRONT / H_SYNC / H_BACK, 40 / 128 / 88, horizontal porch and sync widths in clocks.
V_FRONT / V_SYNC / V_BACK, 1 / 4 / 23, vertical porch and sync widths in lines.

Ports:
clk  in  1  pixel clock.
reset_n  in  1  asynchronous, active-low reset.
enable  in  1  scanout enable; sampled only at frame boundaries.
raddress  out  BUFFER_ADDR_W  read address to the bank = pixel_index / CORES_COUNT.
rselect  out  $clog2(CORES_COUNT)  bank select = pixel_index % CORES_COUNT.
rdata  in  COLOR_WIDTH  bank read data. Valid one clock after raddress/rselect.
vid_pixel  out  COLOR_WIDTH  output pixel; 0 whenever vid_de=0.
vid_de  out  1  active-video data enable.
vid_hsync  out  1  horizontal sync, active high.
vid_vsync  out  1  vertical sync, active high.
frame_start  out  1  one-clock pulse, aligned with the first active pixel of each frame on vid_*.

Behaviour:
- Reset (asynchronous): all outputs 0. h_cnt=0, v_cnt=0, running=0, pixel counters 0, delay pipes cleared.
- Line length is HT = X+H_FRONT+H_SYNC+H_BACK (1056 at defaults).
- Frame height is VT = Y+V_FRONT+V_SYNC+V_BACK (628 at defaults).
- h_cnt counts 0..HT-1 and wraps to 0. v_cnt increments on each h_cnt wrap and wraps 0..VT-1.
- Fetch-stage active = running && h_cnt<X && v_cnt<Y.
- Fetch-stage hs = running && X+H_FRONT <= h_cnt < X+H_FRONT+H_SYNC.
- Fetch-stage vs = running && Y+V_FRONT <= v_cnt < Y+V_FRONT+V_SYNC.
- Address generation is incremental; no divider. Per active cycle:
  - rselect increments.
  - When rselect = CORES_COUNT-1, rselect wraps to 0 and raddress increments.
  - Both return to 0 at frame end, i.e. the h/v wrap to (0,0).
- raddress/rselect are registered. They hold their last value during blanking and are not incremented there.
- Latency: the bank returns data one clock after the address is presented. vid_pixel is registered from rdata.
  - active/hs/vs/first-pixel flags are delayed so vid_* lags the fetch-stage counters by exactly 2 clocks: address register, then output register.
  - vid_pixel = rdata when delayed-active, else 0.
- Pixel n of the frame (n = y*X + x) reads rselect = n%CORES_COUNT, raddress = n/CORES_COUNT.
  - Last pixel at defaults: rselect=9, raddress=47999.
- Enable and frame control:
  - While running=0, counters are held at 0 and all vid_* outputs are 0.
  - running is loaded from enable only when counters are at (0,0): at start-up, or at the wrap out of (HT-1, VT-1).
  - Deasserting enable mid-frame completes the current frame, including blanking, then stops.
  - An enable pulse that lands only mid-frame while stopped is ignored; enable is level-sampled.
- frame_start: fetch-stage flag set at (h=0, v=0, running). It emerges on the output 2 clocks later, coincident with the first vid_de=1.
- Reset mid-frame: immediate return to the reset state. The next frame begins at pixel 0 once enable is high.
- Outputs are glitch-free: all vid_* and frame_start are driven from flops.

Decomposition:
- Package ppu_video_pkg holds:
  - default SVGA timing constants (H_*/V_*);
  - typedef video_out_t {pixel, de, hsync, vsync};
  - a function computing HT/VT.
- Sub-module ppu_video_timing holds the h/v counters, the running flag and the active/hs/vs/first flags.
- ppu_scanout adds address generation, the latency delay pipe and the output register. Total is about 200 RTL lines.

Test Plan:
All scenarios use the bench configuration X=8, Y=4, CORES=4, H 2/2/2, V 1/1/1 (HT=14, VT=7), with a behavioural bank model that returns rdata = {rselect, raddress} one clock after the request.
1. Reset: hold reset_n=0 with enable=1 -> all outputs 0. Release -> first raddress/rselect=(0,0) on the clock after release; vid_de=1 and frame_start=1 two clocks later.
2. Mapping: first frame -> requests (rsel,addr) = (0,0),(1,0),(2,0),(3,0),(0,1),(1,1)... The last active pixel is (3,7). vid_pixel reproduces the encoded values in order. vid_pixel=0 on every de=0 cycle.
3. Timing: count clocks -> each line is 14 clocks with 8 de-high. hsync is high for exactly 2 clocks starting 2 clocks after de falls (delayed domain). vsync spans line 5 only. Frame period is 98 clocks; frame_start pulses every 98 clocks.
4. Enable drop: deassert enable at pixel (3,2) -> the frame completes all 98 clocks, then all outputs stay 0. Reassert enable -> the next frame restarts at (0,0) with frame_start.
5. Reset mid-frame: assert reset_n=0 at line 2 -> outputs go to 0 asynchronously. After release the sequence restarts at raddress=0, rselect=0.
6. Default parameters: one full frame -> 600×800 de-high cycles. The final request is rselect=9, raddress=47999; the frame is 1056×628 clocks.
